// File: rtl/modulo_unit.sv
// rtl/modulo_unit.sv - iterative restoring-division remainder engine, one quotient bit per clock
// Level-driven start; ready pulses once per completion, then waits in HOLD for start to drop.
module modulo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH:0]   t;

  always_comb begin
    state_d     = state_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    r_d         = r_q;
    remainder_d = remainder_q;
    cnt_d       = cnt_q;
    div_zero_d  = div_zero_q;
    // The extra top bit keeps the trial value exact when the divisor MSB is set.
    t           = {r_q, dividend_q[WIDTH-1]};

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (b_i == '0) begin
            remainder_d = a_i;
            div_zero_d  = 1'b1;
            state_d     = DONE;
          end else begin
            dividend_d = a_i;
            divisor_d  = b_i;
            r_d        = '0;
            cnt_d      = CW'(WIDTH - 1);
            state_d    = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (!start_i) begin
          state_d = IDLE;
        end else begin
          dividend_d = {dividend_q[WIDTH-2:0], 1'b0};
          if (t >= {1'b0, divisor_q}) begin
            r_d = WIDTH'(t - {1'b0, divisor_q});
          end else begin
            r_d = t[WIDTH-1:0];
          end
          if (cnt_q == '0) begin
            remainder_d = r_d;
            div_zero_d  = 1'b0;
            state_d     = DONE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      DONE: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (!start_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q     <= IDLE;
      dividend_q  <= '0;
      divisor_q   <= '0;
      r_q         <= '0;
      remainder_q <= '0;
      cnt_q       <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      r_q         <= r_d;
      remainder_q <= remainder_d;
      cnt_q       <= cnt_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign ready_o     = (state_q == DONE);
  assign busy_o      = (state_q == SHIFT);
  assign remainder_o = remainder_q;
  assign div_zero_o  = div_zero_q;

endmodule
